// File: rtl/ex_stage_md_pkg.sv
// Shared RV32 execute-stage types: ALU ops, branch compares, M-extension ops, M-unit FSM states.
// Latency: none (types only).
// Backpressure: none (types only).
package rv32i_types;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        md_mul    = 3'b000,
        md_mulh   = 3'b001,
        md_mulhsu = 3'b010,
        md_mulhu  = 3'b011,
        md_div    = 3'b100,
        md_divu   = 3'b101,
        md_rem    = 3'b110,
        md_remu   = 3'b111
    } md_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/ex_stage_md_muldiv.sv
// M-extension multiply/divide unit: shift-add multiply, restoring divide, on operand magnitudes.
// Latency: XLEN+1 cycles to DONE (2 for FAST_MUL multiply, 1 for divide-by-zero/overflow).
// Backpressure: holds the result in DONE until ack_i; flush_i aborts to IDLE from any busy state.
// Ports: start_i/op_i/a_i/b_i accept an op in IDLE; ack_i retires DONE; state_o/result_o to the stage.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             ack_i,
    input  md_funct3_t       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output md_state_t        state_o,
    output logic [XLEN-1:0]  result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;     // {hi/remainder, lo/multiplier-or-quotient}
    logic [XLEN-1:0]    opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]    res_q, res_d;
    md_funct3_t         op_q, op_d;
    logic               negq_q, negq_d;   // negate product / quotient
    logic               negr_q, negr_d;   // negate remainder (follows dividend sign)

    // Operand decode at acceptance
    logic            is_div, a_neg, b_neg, a_sgn, b_sgn, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = op_i[2];
    assign a_sgn    = (op_i == md_mulh) | (op_i == md_mulhsu) | (op_i == md_div) | (op_i == md_rem);
    assign b_sgn    = (op_i == md_mulh) | (op_i == md_div) | (op_i == md_rem);
    assign a_neg    = a_sgn & a_i[XLEN-1];
    assign b_neg    = b_sgn & b_i[XLEN-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign div_zero = (b_i == '0);
    assign div_ovf  = b_sgn & (a_i == MIN_NEG) & (b_i == '1);

    // One iteration of each algorithm
    logic [XLEN:0]     mul_sum, div_r, div_sub;
    logic [2*XLEN-1:0] mul_step, div_step, fast_prod;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_r     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_sub   = div_r - {1'b0, opb_q};
        // No borrow means the shifted remainder covered the divisor
        div_step  = div_sub[XLEN] ? {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        fast_prod = {{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, opb_q};
    end

    // Sign-correct the raw magnitude result and pick the architectural half
    function automatic logic [XLEN-1:0] md_finish(input logic [2*XLEN-1:0] acc,
                                                  input md_funct3_t op,
                                                  input logic nq, input logic nr);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r, res;
        p = nq ? -acc : acc;
        q = nq ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = nr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op[2])
            res = (op == md_mul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else
            res = op[1] ? r : q;
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        res_d   = res_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d   = op_i;
                    opb_d  = b_mag;
                    acc_d  = {{XLEN{1'b0}}, a_mag};
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    cnt_d  = '0;
                    if (is_div && div_zero) begin
                        res_d   = op_i[1] ? a_i : '1;
                        state_d = DONE;
                    end else if (is_div && div_ovf) begin
                        res_d   = op_i[1] ? '0 : a_i;
                        state_d = DONE;
                    end else begin
                        state_d = is_div ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                if (FAST_MUL) begin
                    res_d   = md_finish(fast_prod, op_q, negq_q, negr_q);
                    state_d = DONE;
                end else begin
                    acc_d = mul_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        res_d   = md_finish(mul_step, op_q, negq_q, negr_q);
                        state_d = DONE;
                    end
                end
            end
            DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = md_finish(div_step, op_q, negq_q, negr_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i && (state_q != IDLE))
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            op_q    <= md_mul;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign state_o  = state_q;
    assign result_o = res_q;

endmodule

// File: rtl/ex_stage_md.sv
// RV32 execute stage: forwarding, ALU, branch compare, and an iterative M-extension unit.
// Latency: ALU/compare combinational; M ops complete via muldiv_unit (result held in DONE).
// Backpressure: ex_stall holds IF/ID/EX while an M op runs or DONE waits on out_ready.
// Ports: operand/immediate/forward inputs, mux selects, ex_result/ex_cmp_out/ex_result_valid/ex_stall.
module ex_stage_md
    import rv32i_types::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic             out_ready,
    input  logic             ex_alumux1_sel,
    input  logic [2:0]       ex_alumux2_sel,
    input  logic             ex_cmpmux_sel,
    input  logic [1:0]       ex_fwd_sel1,
    input  logic [1:0]       ex_fwd_sel2,
    input  alu_ops           ex_aluop,
    input  branch_funct3_t   ex_cmpop,
    input  logic             ex_is_md,
    input  md_funct3_t       ex_mdop,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1_out,
    input  logic [XLEN-1:0]  ex_rs2_out,
    input  logic [XLEN-1:0]  ex_i_imm,
    input  logic [XLEN-1:0]  ex_u_imm,
    input  logic [XLEN-1:0]  ex_b_imm,
    input  logic [XLEN-1:0]  ex_s_imm,
    input  logic [XLEN-1:0]  ex_j_imm,
    input  logic [XLEN-1:0]  ex_rs1_fwd_wb,
    input  logic [XLEN-1:0]  ex_rs2_fwd_wb,
    input  logic [XLEN-1:0]  ex_rs1_fwd_mem,
    input  logic [XLEN-1:0]  ex_rs2_fwd_mem,
    output logic [XLEN-1:0]  ex_result,
    output logic [XLEN-1:0]  ex_cmp_out,
    output logic             ex_result_valid,
    output logic             ex_stall
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, alumux1, alumux2, cmpmux, alu_out, md_result;
    logic            br_en, md_start;
    md_state_t       md_state;

    function automatic logic [XLEN-1:0] alu_f(input alu_ops op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SW-1:0]   sh;
        logic [XLEN-1:0] r;
        sh = b[SW-1:0];
        case (op)
            alu_add: r = a + b;
            alu_sll: r = a << sh;
            alu_sra: r = $signed(a) >>> sh;
            alu_sub: r = a - b;
            alu_xor: r = a ^ b;
            alu_srl: r = a >> sh;
            alu_or:  r = a | b;
            alu_and: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic cmp_f(input branch_funct3_t op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        logic r;
        case (op)
            beq:     r = (a == b);
            bne:     r = (a != b);
            blt:     r = ($signed(a) <  $signed(b));
            bge:     r = ($signed(a) >= $signed(b));
            bltu:    r = (a <  b);
            bgeu:    r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Forwarding resolves operands first so ALU, compare and M-unit all see the same values
    always_comb begin
        case (ex_fwd_sel1)
            2'd1:    rs1_fwd = ex_rs1_fwd_wb;
            2'd2:    rs1_fwd = ex_rs1_fwd_mem;
            default: rs1_fwd = ex_rs1_out;
        endcase
        case (ex_fwd_sel2)
            2'd1:    rs2_fwd = ex_rs2_fwd_wb;
            2'd2:    rs2_fwd = ex_rs2_fwd_mem;
            default: rs2_fwd = ex_rs2_out;
        endcase
        alumux1 = ex_alumux1_sel ? ex_pc : rs1_fwd;
        case (ex_alumux2_sel)
            3'd0:    alumux2 = ex_i_imm;
            3'd1:    alumux2 = ex_u_imm;
            3'd2:    alumux2 = ex_b_imm;
            3'd3:    alumux2 = ex_s_imm;
            3'd4:    alumux2 = rs2_fwd;
            3'd5:    alumux2 = ex_j_imm;
            default: alumux2 = '0;
        endcase
        cmpmux  = ex_cmpmux_sel ? ex_i_imm : rs2_fwd;
        alu_out = alu_f(ex_aluop, alumux1, alumux2);
        br_en   = cmp_f(ex_cmpop, rs1_fwd, cmpmux);
    end

    assign md_start = ex_valid & ex_is_md & ~ex_flush & ~rst;

    muldiv_unit #(
        .XLEN     (XLEN),
        .FAST_MUL (FAST_MUL)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .flush_i  (ex_flush),
        .ack_i    (out_ready),
        .op_i     (ex_mdop),
        .a_i      (rs1_fwd),
        .b_i      (rs2_fwd),
        .state_o  (md_state),
        .result_o (md_result)
    );

    // Outputs are forced quiet while rst is high, since the FSM only clears on the edge
    always_comb begin
        ex_result       = '0;
        ex_cmp_out      = '0;
        ex_result_valid = 1'b0;
        ex_stall        = 1'b0;
        if (!rst) begin
            case (md_state)
                IDLE: begin
                    if (ex_valid && !ex_is_md) begin
                        ex_result       = alu_out;
                        ex_cmp_out      = {{(XLEN-1){1'b0}}, br_en};
                        ex_result_valid = ~ex_flush;
                    end
                    ex_stall = md_start;
                end
                MUL, DIV: begin
                    ex_result = md_result;
                    ex_stall  = 1'b1;
                end
                DONE: begin
                    ex_result       = md_result;
                    ex_result_valid = ~ex_flush;
                    ex_stall        = ~out_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;
    import rv32i_types::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           ex_valid, ex_flush, out_ready;
    logic           ex_alumux1_sel;
    logic [2:0]     ex_alumux2_sel;
    logic           ex_cmpmux_sel;
    logic [1:0]     ex_fwd_sel1, ex_fwd_sel2;
    alu_ops         ex_aluop;
    branch_funct3_t ex_cmpop;
    logic           ex_is_md;
    md_funct3_t     ex_mdop;
    logic [31:0]    ex_pc, ex_rs1_out, ex_rs2_out;
    logic [31:0]    ex_i_imm, ex_u_imm, ex_b_imm, ex_s_imm, ex_j_imm;
    logic [31:0]    ex_rs1_fwd_wb, ex_rs2_fwd_wb, ex_rs1_fwd_mem, ex_rs2_fwd_mem;
    logic [31:0]    ex_result, ex_cmp_out;
    logic           ex_result_valid, ex_stall;

    int total = 0;
    int bad   = 0;

    ex_stage_md #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush), .out_ready(out_ready),
        .ex_alumux1_sel(ex_alumux1_sel), .ex_alumux2_sel(ex_alumux2_sel),
        .ex_cmpmux_sel(ex_cmpmux_sel), .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2),
        .ex_aluop(ex_aluop), .ex_cmpop(ex_cmpop), .ex_is_md(ex_is_md), .ex_mdop(ex_mdop),
        .ex_pc(ex_pc), .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out),
        .ex_i_imm(ex_i_imm), .ex_u_imm(ex_u_imm), .ex_b_imm(ex_b_imm), .ex_s_imm(ex_s_imm),
        .ex_j_imm(ex_j_imm), .ex_rs1_fwd_wb(ex_rs1_fwd_wb), .ex_rs2_fwd_wb(ex_rs2_fwd_wb),
        .ex_rs1_fwd_mem(ex_rs1_fwd_mem), .ex_rs2_fwd_mem(ex_rs2_fwd_mem),
        .ex_result(ex_result), .ex_cmp_out(ex_cmp_out),
        .ex_result_valid(ex_result_valid), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ex_valid = 0; ex_flush = 0; out_ready = 0;
        ex_alumux1_sel = 0; ex_alumux2_sel = 3'd0; ex_cmpmux_sel = 0;
        ex_fwd_sel1 = 2'd0; ex_fwd_sel2 = 2'd0;
        ex_aluop = alu_add; ex_cmpop = beq; ex_is_md = 0; ex_mdop = md_mul;
        ex_pc = 0; ex_rs1_out = 0; ex_rs2_out = 0;
        ex_i_imm = 0; ex_u_imm = 0; ex_b_imm = 0; ex_s_imm = 0; ex_j_imm = 0;
        ex_rs1_fwd_wb = 0; ex_rs2_fwd_wb = 0; ex_rs1_fwd_mem = 0; ex_rs2_fwd_mem = 0;
    endtask

    // Present an M op at a negedge; when via_mem is set, rs1 arrives through the MEM forward path
    task automatic issue_md(input md_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                            input bit via_mem);
        @(negedge clk);
        ex_valid = 1; ex_is_md = 1; ex_mdop = op; out_ready = 0;
        ex_fwd_sel2 = 2'd0; ex_rs2_out = b;
        if (via_mem) begin
            ex_fwd_sel1 = 2'd2; ex_rs1_out = 32'h0; ex_rs1_fwd_mem = a;
        end else begin
            ex_fwd_sel1 = 2'd0; ex_rs1_out = a;
        end
        #1;
    endtask

    // Count edges from acceptance until result_valid; also report whether stall stayed high
    task automatic wait_done(output int cyc, output bit all_stall);
        cyc = 0;
        all_stall = 1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            cyc++;
            if (ex_result_valid) break;
            if (!ex_stall) all_stall = 0;
        end
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
        ex_valid = 0; ex_is_md = 0; out_ready = 0; ex_fwd_sel1 = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (ex_result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ex_result_valid); end
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", ex_stall); end
        total++; if (ex_result !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", ex_result); end
        ex_valid = 1; ex_is_md = 1; ex_mdop = md_div; ex_rs1_out = 9; ex_rs2_out = 3;
        #1;
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL rst_md_stall: got %b want 0", ex_stall); end
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1;
        total++; if (ex_result_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", ex_result_valid); end
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall: got %b want 0", ex_stall); end
        @(posedge clk); #1;
        total++; if (ex_result !== 32'h0) begin bad++; $display("FAIL post_rst_result: got %h want 0", ex_result); end
    endtask

    task automatic test_alu_fwd();
        @(negedge clk);
        ex_valid = 1; ex_aluop = alu_add; ex_alumux2_sel = 3'd4;
        ex_rs1_out = 5; ex_rs2_out = 7; ex_fwd_sel1 = 2'd2; ex_rs1_fwd_mem = 100;
        #1;
        total++; if (ex_result !== 32'd107) begin bad++; $display("FAIL add_mem_fwd: got %0d want 107", ex_result); end
        total++; if (ex_result_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", ex_result_valid); end
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL add_stall: got %b want 0", ex_stall); end
        ex_fwd_sel1 = 2'd3; #1;
        total++; if (ex_result !== 32'd12) begin bad++; $display("FAIL add_sel3: got %0d want 12", ex_result); end
        ex_aluop = alu_sub; ex_fwd_sel1 = 2'd1; ex_rs1_fwd_wb = 50; ex_fwd_sel2 = 2'd2; ex_rs2_fwd_mem = 8; #1;
        total++; if (ex_result !== 32'd42) begin bad++; $display("FAIL sub_fwd: got %0d want 42", ex_result); end
        ex_aluop = alu_add; ex_alumux1_sel = 1; ex_pc = 32'h1000; ex_alumux2_sel = 3'd0; ex_i_imm = 32'h10; #1;
        total++; if (ex_result !== 32'h1010) begin bad++; $display("FAIL pc_imm: got %h want 00001010", ex_result); end
        ex_alumux2_sel = 3'd6; #1;
        total++; if (ex_result !== 32'h1000) begin bad++; $display("FAIL mux2_zero: got %h want 00001000", ex_result); end
        ex_aluop = alu_sra; ex_alumux1_sel = 0; ex_fwd_sel1 = 2'd0; ex_rs1_out = 32'h8000_0000;
        ex_alumux2_sel = 3'd1; ex_u_imm = 32'd4; #1;
        total++; if (ex_result !== 32'hF800_0000) begin bad++; $display("FAIL sra: got %h want f8000000", ex_result); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_cmp();
        @(negedge clk);
        ex_valid = 1; ex_cmpop = beq; ex_rs1_out = 9; ex_rs2_out = 4; ex_fwd_sel2 = 2'd1; ex_rs2_fwd_wb = 9; #1;
        total++; if (ex_cmp_out !== 32'd1) begin bad++; $display("FAIL beq_wb: got %h want 1", ex_cmp_out); end
        ex_fwd_sel2 = 2'd3; #1;
        total++; if (ex_cmp_out !== 32'd0) begin bad++; $display("FAIL beq_sel3: got %h want 0", ex_cmp_out); end
        ex_fwd_sel1 = 2'd2; ex_rs1_fwd_mem = 4; #1;
        total++; if (ex_cmp_out !== 32'd1) begin bad++; $display("FAIL beq_rs1_mem: got %h want 1", ex_cmp_out); end
        ex_fwd_sel1 = 2'd0; ex_fwd_sel2 = 2'd0; ex_cmpop = blt; ex_rs1_out = 32'hFFFF_FFFF; ex_rs2_out = 1; #1;
        total++; if (ex_cmp_out !== 32'd1) begin bad++; $display("FAIL blt: got %h want 1", ex_cmp_out); end
        ex_cmpop = bltu; #1;
        total++; if (ex_cmp_out !== 32'd0) begin bad++; $display("FAIL bltu: got %h want 0", ex_cmp_out); end
        ex_cmpop = bgeu; ex_cmpmux_sel = 1; ex_i_imm = 32'hFFFF_FFFF; #1;
        total++; if (ex_cmp_out !== 32'd1) begin bad++; $display("FAIL bgeu_imm: got %h want 1", ex_cmp_out); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_mul();
        md_funct3_t  ops [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] exp [4];
        bit          mem [4];
        int          cyc;
        bit          st;
        ops = '{md_mul, md_mulhu, md_mulh, md_mulhsu};
        va  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        vb  = '{32'd2, 32'd2, 32'd3, 32'd2};
        exp = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        mem = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            issue_md(ops[i], va[i], vb[i], mem[i]);
            total++; if (ex_stall !== 1'b1) begin bad++; $display("FAIL mul%0d_accept_stall: got %b want 1", i, ex_stall); end
            wait_done(cyc, st);
            total++; if (cyc != 33) begin bad++; $display("FAIL mul%0d_latency: got %0d want 33", i, cyc); end
            total++; if (st !== 1'b1) begin bad++; $display("FAIL mul%0d_busy_stall: got %b want 1", i, st); end
            total++; if (ex_result !== exp[i]) begin bad++; $display("FAIL mul%0d_result: got %h want %h", i, ex_result, exp[i]); end
            total++; if (ex_cmp_out !== 32'd0) begin bad++; $display("FAIL mul%0d_cmp: got %h want 0", i, ex_cmp_out); end
            total++; if (ex_stall !== 1'b1) begin bad++; $display("FAIL mul%0d_done_stall: got %b want 1", i, ex_stall); end
            out_ready = 1; #1;
            total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL mul%0d_ready_stall: got %b want 0", i, ex_stall); end
            retire();
        end
    endtask

    task automatic test_div_special();
        md_funct3_t  ops [5];
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] exp [5];
        int          cyc;
        bit          st;
        ops = '{md_div, md_rem, md_divu, md_remu, md_div};
        va  = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7, 32'hFFFF_FFFB};
        vb  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        exp = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            issue_md(ops[i], va[i], vb[i], 0);
            wait_done(cyc, st);
            total++; if (cyc != 1) begin bad++; $display("FAIL divsp%0d_latency: got %0d want 1", i, cyc); end
            total++; if (ex_result !== exp[i]) begin bad++; $display("FAIL divsp%0d_result: got %h want %h", i, ex_result, exp[i]); end
            out_ready = 1;
            retire();
        end
    endtask

    task automatic test_div_signed();
        md_funct3_t  ops [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] exp [4];
        int          cyc;
        bit          st;
        ops = '{md_div, md_rem, md_divu, md_remu};
        va  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        vb  = '{32'd2, 32'd2, 32'd7, 32'd7};
        exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue_md(ops[i], va[i], vb[i], 0);
            wait_done(cyc, st);
            total++; if (cyc != 33) begin bad++; $display("FAIL div%0d_latency: got %0d want 33", i, cyc); end
            total++; if (ex_result !== exp[i]) begin bad++; $display("FAIL div%0d_result: got %h want %h", i, ex_result, exp[i]); end
            if (i == 1) begin
                for (int h = 0; h < 3; h++) begin
                    @(posedge clk); @(negedge clk); #1;
                    total++; if (ex_result !== exp[i] || ex_result_valid !== 1'b1)
                        begin bad++; $display("FAIL rem_hold%0d: got %h/%b want %h/1", h, ex_result, ex_result_valid, exp[i]); end
                    total++; if (ex_stall !== 1'b1) begin bad++; $display("FAIL rem_hold%0d_stall: got %b want 1", h, ex_stall); end
                end
            end
            out_ready = 1;
            retire();
        end
    endtask

    // Abort a DIVU mid-iteration by flush (kind=0) or reset (kind=1), then run an ADD
    task automatic test_abort();
        int vcount;
        for (int kind = 0; kind < 2; kind++) begin
            issue_md(md_divu, 32'd1000, 32'd3, 0);
            repeat (11) @(posedge clk);
            @(negedge clk);
            if (kind == 0) ex_flush = 1; else rst = 1;
            #1;
            total++; if (ex_result_valid !== 1'b0) begin bad++; $display("FAIL abort%0d_valid: got %b want 0", kind, ex_result_valid); end
            @(posedge clk); #1;
            ex_flush = 0; rst = 0; ex_valid = 0; ex_is_md = 0;
            @(negedge clk); #1;
            total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL abort%0d_idle_stall: got %b want 0", kind, ex_stall); end
            total++; if (kind == 1 && ex_result !== 32'h0) begin bad++; $display("FAIL abort1_result: got %h want 0", ex_result); end
            vcount = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk); #1;
                if (ex_result_valid) vcount++;
            end
            total++; if (vcount != 0) begin bad++; $display("FAIL abort%0d_stray_valid: got %0d want 0", kind, vcount); end
            @(negedge clk);
            ex_valid = 1; ex_aluop = alu_add; ex_alumux2_sel = 3'd4; ex_rs1_out = 2; ex_rs2_out = 3; #1;
            total++; if (ex_result !== 32'd5 || ex_result_valid !== 1'b1)
                begin bad++; $display("FAIL abort%0d_add: got %0d/%b want 5/1", kind, ex_result, ex_result_valid); end
            total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL abort%0d_add_stall: got %b want 0", kind, ex_stall); end
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_alu_fwd();
        test_cmp();
        test_mul();
        test_div_special();
        test_div_signed();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
